input_queue: RTL and testbench
==============================

# input_queue

Debounced front-panel input queue between the board switches/buttons and the CPU `in` port. Pressing the push button captures the switch value into a parametrised circular FIFO. The CPU side drains entries through a valid/ready handshake, so several operands can be entered ahead of the program. It replaces the direct `sw` to `in` wiring and adds debouncing, buffering, sign extension, overflow detection and flush.

## Interface
- `IN_WIDTH`, 4: switch field width; must be ≤ `DATA_WIDTH`.
- `DATA_WIDTH`, 16: width of each output entry.
- `DEPTH_LOG2`, 3: FIFO depth is 2**`DEPTH_LOG2` entries.
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles needed to accept a level change. Use 50_000 on board; must be ≥ 1.
- `SIGN_EXT`, 0: 0 zero-extends `sw` to `DATA_WIDTH`; 1 sign-extends from bit `IN_WIDTH`-1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn`  in  2  raw, asynchronous, active-high (1 = pressed). [0] is push, [1] is flush.
- `sw`  in  `IN_WIDTH`  raw switch value.
- `out_data`  out  `DATA_WIDTH`  head entry, extended per `SIGN_EXT`; 0 when empty.
- `out_valid`  out  1  queue non-empty.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `count`  out  `DEPTH_LOG2`+1  number of stored entries.
- `full`  out  1  count == depth.
- `empty`  out  1  count == 0.
- `overflow`  out  1  sticky; a push was dropped because the queue was full.

## Operation
- Synchronisers: `btn` and `sw` each pass through a 2-flop synchroniser (`s1`, then `s2`).
- Debouncer, one per button, each holding a stable level `db` and a counter:
  - when `s2` != `db`, the counter increments;
  - on the `DEBOUNCE_CYCLES`-th consecutive differing cycle, `db` <= `s2` and the counter clears;
  - any cycle with `s2` == `db` clears the counter.
- Press pulse: a registered pulse, high for exactly one cycle in the first cycle `db` reads 1. Releases produce no pulse. Holding a button yields a single press.
- Push, on a push press:
  - the synchronised `sw` is written at the write pointer, the pointer advances, and count increments;
  - if the queue is full and no pop occurs that cycle, the entry is dropped and `overflow` <= 1.
- Pop:
  - occurs when `out_valid` && `out_ready`; the read pointer advances and count decrements;
  - `out_ready` while empty has no effect.
- Simultaneous push and pop:
  - both succeed and count is unchanged, including when full (no overflow);
  - when empty, only the push occurs.
- Flush, on a flush press:
  - pointers, count and `overflow` clear next edge;
  - it takes priority: a push or pop in the same cycle is discarded.
- Pointers are `DEPTH_LOG2` bits and wrap modulo depth. Storage is a register array, not reset.
- Extension: `out_data` = `{{DATA_WIDTH-IN_WIDTH}{SIGN_EXT ? bit[IN_WIDTH-1] : 0}}, entry}`.

## Timing
- Reset: `out_data`=0, `out_valid`=0, `count`=0, `full`=0, `empty`=1, `overflow`=0. Synchronisers, `db`, counters and press pulses all clear to 0.
- Reset mid-debounce discards partial progress. A button held through reset produces one press `DEBOUNCE_CYCLES`+2 edges after `rst` deasserts.
- Press latency: raw `btn` high before edge E0 gives `s2`=1 after E1 and press high after E(1+`DEBOUNCE_CYCLES`). The switch value captured is `s2` of `sw` in the press cycle.
- Write to visibility: the entry is stored at the edge ending the press cycle. `out_valid`, `count` and `out_data` update in the following cycle.
- `out_data` is show-ahead, combinational from the head register. After a pop edge the next entry is visible immediately.
- Outputs `count`, `full`, `empty` and `overflow` are all registered or derived from registered state; none depends combinationally on `out_ready`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `DEPTH_LOG2`=2, `IN_WIDTH`=4, `DATA_WIDTH`=16.
- Bounce: `btn[0]` toggles every cycle for 8 cycles, then stays 0 -> no push; `count`=0 and `empty`=1 throughout.
- Single push: `sw`=4'hA, `btn[0]` held 12 cycles -> exactly one entry; `out_valid`=1 seven edges after the first high sample. `out_data`=16'h000A; with `SIGN_EXT`=1 it is 16'hFFFA.
- Overflow and order: with `out_ready`=0, push `sw`=1,2,3,4,5 -> `count`=4, `full`=1, `overflow`=1, head 16'h0001. Then `out_ready`=1 pops 1,2,3,4 on consecutive cycles, ending `empty`=1.
- Full push+pop: queue full with 1,2,3,4; push 5 in the same cycle as a pop -> `count` stays 4, `overflow` stays 0, subsequent pops give 2,3,4,5.
- Flush: 3 entries and `overflow`=1; flush press coinciding with a push press -> next cycle `count`=0, `overflow`=0, `out_data`=0.
- Reset mid-operation: 2 entries stored and `btn[0]` mid-debounce when `rst`=1 for 1 cycle with `btn` released -> all outputs at reset values and no later push.

Source files
------------

// File: rtl/input_queue.sv
`default_nettype none
// ============================================================================
// Module   : input_queue
// Purpose  : Front-panel input queue. Synchronises and debounces the two
//            buttons, captures the switch value into a circular FIFO on each
//            push press, and serves entries to the CPU through a valid/ready
//            handshake with show-ahead data, sign/zero extension, a sticky
//            overflow flag and a flush button.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            btn_i[1:0]    - raw buttons, [0] push, [1] flush
//            sw_i          - raw switch value
//            out_data_o    - extended head entry (0 when empty)
//            out_valid_o   - queue non-empty
//            out_ready_i   - consumer accepts head this cycle
//            count_o       - stored entries
//            full_o/empty_o/overflow_o - status flags
// Revision : 1.0 - initial release
// ============================================================================
module input_queue #(
   parameter int IN_WIDTH        = 4,
   parameter int DATA_WIDTH      = 16,
   parameter int DEPTH_LOG2      = 3,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SIGN_EXT        = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            btn_i,
   input  logic [IN_WIDTH-1:0]   sw_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  overflow_o
);

   localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DEPTH_LOG2:0] c_DEPTH  = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;

   // Two-flop synchronisers
   logic [1:0]          btn_s1_q, btn_s2_q;
   logic [IN_WIDTH-1:0] sw_s1_q,  sw_s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_s1_q <= '0;
         btn_s2_q <= '0;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
      end else begin
         btn_s1_q <= btn_i;
         btn_s2_q <= btn_s1_q;
         sw_s1_q  <= sw_i;
         sw_s2_q  <= sw_s1_q;
      end
   end

   // One debouncer per button; press pulse fires on the edge db rises
   logic [1:0] w_press;

   for (genvar g = 0; g < 2; g++) begin : g_db
      logic             db_q;
      logic             press_q;
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            db_q    <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
         end else begin
            press_q <= 1'b0;
            if (btn_s2_q[g] != db_q) begin
               if (cnt_q == c_CNT_LAST) begin
                  db_q    <= btn_s2_q[g];
                  press_q <= btn_s2_q[g];
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end else begin
               cnt_q <= '0;
            end
         end
      end

      assign w_press[g] = press_q;
   end

   // FIFO state
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q,  count_d;
   logic                  ovf_q,    ovf_d;
   logic [IN_WIDTH-1:0]   mem_q [0:(1<<DEPTH_LOG2)-1];

   logic w_push, w_flush, w_pop, w_wr_en, w_full;

   assign w_push  = w_press[0];
   assign w_flush = w_press[1];
   assign w_full  = (count_q == c_DEPTH);
   assign w_pop   = (count_q != '0) && out_ready_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      w_wr_en  = 1'b0;
      if (w_flush) begin
         // Flush wins over any push or pop in the same cycle
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         // A pop frees the slot in the same cycle, so a full queue still accepts
         if (w_push && (!w_full || w_pop)) begin
            w_wr_en  = 1'b1;
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
         end else if (w_push) begin
            ovf_d = 1'b1;
         end
         if (w_pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
         end
         case ({w_wr_en, w_pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage carries no reset; stale contents are masked while empty
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         mem_q[wr_ptr_q] <= sw_s2_q;
      end
   end

   logic [IN_WIDTH-1:0]   w_head;
   logic [DATA_WIDTH-1:0] w_ext;

   assign w_head = mem_q[rd_ptr_q];

   if (DATA_WIDTH > IN_WIDTH) begin : g_ext
      logic w_fill;
      assign w_fill = (SIGN_EXT != 0) ? w_head[IN_WIDTH-1] : 1'b0;
      assign w_ext  = {{(DATA_WIDTH-IN_WIDTH){w_fill}}, w_head};
   end else begin : g_noext
      assign w_ext = w_head;
   end

   assign out_valid_o = (count_q != '0);
   assign out_data_o  = out_valid_o ? w_ext : '0;
   assign count_o     = count_q;
   assign full_o      = w_full;
   assign empty_o     = (count_q == '0);
   assign overflow_o  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_input_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_queue
// Purpose  : Self-checking bench for input_queue. Expected entries are pushed
//            to a scoreboard queue when a push is driven and compared against
//            the DUT head when it is popped.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  btn;
   logic [3:0]  sw;
   logic        out_ready;

   logic [15:0] out_data, out_data_se;
   logic        out_valid, out_valid_se;
   logic [2:0]  count, count_se;
   logic        full, empty, overflow;
   logic        full_se, empty_se, overflow_se;

   input_queue #(
      .IN_WIDTH(4), .DATA_WIDTH(16), .DEPTH_LOG2(2),
      .DEBOUNCE_CYCLES(4), .SIGN_EXT(0)
   ) dut (
      .clk(clk), .rst(rst), .btn_i(btn), .sw_i(sw),
      .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .count_o(count), .full_o(full), .empty_o(empty), .overflow_o(overflow)
   );

   input_queue #(
      .IN_WIDTH(4), .DATA_WIDTH(16), .DEPTH_LOG2(2),
      .DEBOUNCE_CYCLES(4), .SIGN_EXT(1)
   ) dut_se (
      .clk(clk), .rst(rst), .btn_i(btn), .sw_i(sw),
      .out_data_o(out_data_se), .out_valid_o(out_valid_se), .out_ready_i(out_ready),
      .count_o(count_se), .full_o(full_se), .empty_o(empty_se), .overflow_o(overflow_se)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_q [$];
   logic        model_ovf;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Full press/release of the push button; model decides accept vs drop
   task automatic push_val(input logic [3:0] v);
      sw     = v;
      btn[0] = 1'b1;
      tick(7);
      btn[0] = 1'b0;
      tick(7);
      if (exp_q.size() < 4) exp_q.push_back({12'h000, v});
      else                  model_ovf = 1'b1;
   endtask

   task automatic flush_press();
      btn[1] = 1'b1;
      tick(7);
      btn[1] = 1'b0;
      tick(7);
      exp_q.delete();
      model_ovf = 1'b0;
   endtask

   // Pop everything the DUT presents, comparing against the scoreboard
   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (!out_valid) break;
         if (exp_q.size() == 0) check_eq("sb_extra", 32'(out_valid), 32'd0);
         else                   check_eq("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
         tick(1);
      end
      out_ready = 1'b0;
      check_eq("sb_left", 32'(exp_q.size()), 32'd0);
      check_eq("drain_empty", 32'(empty), 32'd1);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_data"},  32'(out_data),  32'd0);
      check_eq({pfx, "_valid"}, 32'(out_valid), 32'd0);
      check_eq({pfx, "_count"}, 32'(count),     32'd0);
      check_eq({pfx, "_full"},  32'(full),      32'd0);
      check_eq({pfx, "_empty"}, 32'(empty),     32'd1);
      check_eq({pfx, "_ovf"},   32'(overflow),  32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      btn       = 2'b00;
      sw        = 4'h0;
      out_ready = 1'b0;
      model_ovf = 1'b0;
      tick(3);
      check_reset_outputs("rst");
      rst = 1'b0;
      tick(2);

      // Bounce: toggle push every cycle, never stable long enough
      for (int i = 0; i < 8; i++) begin
         btn[0] = ~btn[0];
         tick(1);
         check_eq("bounce_count", 32'(count), 32'd0);
      end
      btn[0] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check_eq("bounce_empty", 32'(empty), 32'd1);
      end

      // Single push held 12 cycles
      sw     = 4'hA;
      btn[0] = 1'b1;
      tick(6);
      check_eq("single_valid_early", 32'(out_valid), 32'd0);
      tick(1);
      check_eq("single_valid",   32'(out_valid),   32'd1);
      check_eq("single_data",    32'(out_data),    32'h000A);
      check_eq("single_data_se", 32'(out_data_se), 32'hFFFA);
      tick(5);
      btn[0] = 1'b0;
      tick(8);
      check_eq("single_count", 32'(count), 32'd1);
      exp_q.push_back(16'h000A);
      drain();

      // Overflow and ordering
      for (int v = 1; v <= 5; v++) push_val(4'(v));
      check_eq("of_count", 32'(count),    32'd4);
      check_eq("of_full",  32'(full),     32'd1);
      check_eq("of_ovf",   32'(overflow), 32'(model_ovf));
      check_eq("of_head",  32'(out_data), 32'(exp_q[0]));
      drain();

      flush_press();
      check_eq("fl1_ovf", 32'(overflow), 32'(model_ovf));

      // Full queue, push coinciding with a pop
      for (int v = 1; v <= 4; v++) push_val(4'(v));
      sw     = 4'h5;
      btn[0] = 1'b1;
      tick(6);
      out_ready = 1'b1;
      check_eq("fp_head", 32'(out_data), 32'(exp_q.pop_front()));
      tick(1);
      out_ready = 1'b0;
      exp_q.push_back(16'h0005);
      check_eq("fp_count", 32'(count),    32'd4);
      check_eq("fp_ovf",   32'(overflow), 32'd0);
      btn[0] = 1'b0;
      tick(8);
      check_eq("fp_count2", 32'(count), 32'd4);
      drain();

      // Flush coinciding with a push, from 3 entries with overflow set
      for (int v = 1; v <= 5; v++) push_val(4'(v));
      check_eq("fl_head", 32'(out_data), 32'(exp_q.pop_front()));
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      check_eq("fl_count3", 32'(count),    32'd3);
      check_eq("fl_ovf1",   32'(overflow), 32'(model_ovf));
      sw  = 4'h9;
      btn = 2'b11;
      tick(7);
      check_eq("fl_count", 32'(count),    32'd0);
      check_eq("fl_ovf",   32'(overflow), 32'd0);
      check_eq("fl_data",  32'(out_data), 32'd0);
      btn = 2'b00;
      tick(8);
      exp_q.delete();
      model_ovf = 1'b0;
      check_eq("fl_after", 32'(count), 32'd0);

      // Reset mid-operation with a push in flight
      push_val(4'h7);
      push_val(4'h8);
      check_eq("mr_count", 32'(count), 32'd2);
      btn[0] = 1'b1;
      tick(3);
      btn[0] = 1'b0;
      rst    = 1'b1;
      tick(1);
      rst = 1'b0;
      exp_q.delete();
      model_ovf = 1'b0;
      check_reset_outputs("mr");
      tick(15);
      check_eq("mr_nopush", 32'(count), 32'd0);
      check_eq("mr_empty",  32'(empty), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
